// File: rtl/control_unit_if.sv
// Control-signal interface between the microcoded sequencer and the
// 8-bit bus computer datapath.
//
// Signalling: there is no valid/ready pair. The master drives a complete
// control word every cycle; it is valid from the rising edge that entered
// the current microstep until the next rising edge. The slave samples it
// on that next edge. irval/cf/zf flow from the datapath back to the master
// and are treated as always valid.
interface control_unit_if #(
    parameter int N = 8,
    parameter int S = 3
);
    logic [N-1:0] irval;
    logic         cf;
    logic         zf;
    logic [S-1:0] stepval;
    logic         halted;
    logic         hlt, mi, ri, ro, io, ii, ai, ao;
    logic         eo, su, bi, oi, ce, co, j, fi;

    modport master (
        input  irval, cf, zf,
        output stepval, halted,
        output hlt, mi, ri, ro, io, ii, ai, ao,
        output eo, su, bi, oi, ce, co, j, fi
    );

    modport slave (
        output irval, cf, zf,
        input  stepval, halted,
        input  hlt, mi, ri, ro, io, ii, ai, ao,
        input  eo, su, bi, oi, ce, co, j, fi
    );
endinterface

// File: rtl/control_unit.sv
// Microcoded sequencer for the 8-bit bus computer. A microstep counter and
// a halted bit form the only state; the control word is decoded
// combinationally from step, opcode, flags, halted, prog and clr_.
module control_unit #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic            clk,
    input  logic            clr_,
    input  logic            prog,
    control_unit_if.master  bus
);
    typedef enum logic [S-1:0] {
        T0 = 0,
        T1 = 1,
        T2 = 2,
        T3 = 3,
        T4 = 4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions of each line inside the packed control word.
    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    step_t       step, step_next;
    logic        halted, halted_next;
    logic [3:0]  opcode;
    step_t       last_step;
    logic [15:0] cw;

    assign opcode = bus.irval[N-1 -: 4];

    // Final microstep of the current opcode; the counter wraps after it.
    always_comb begin
        last_step = T2;
        case (opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
    end

    // State register: step counter and halted bit, cleared asynchronously.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            halted <= halted_next;
        end
    end

    // Next-state: park at step 0 in program mode, freeze while halted,
    // latch halt at step 2 of HLT, otherwise advance and wrap.
    always_comb begin
        step_next   = step;
        halted_next = halted;
        if (!prog) begin
            step_next = T0;
        end else if (!halted) begin
            if (step == T2 && opcode == OP_HLT) begin
                halted_next = 1'b1;
            end else if (step >= last_step) begin
                step_next = T0;
            end else begin
                step_next = step_t'(step + 1'b1);
            end
        end
    end

    // Control word decode; everything is forced low during reset and in
    // program mode so manual RAM loading is never disturbed.
    always_comb begin
        cw = '0;
        if (clr_ && prog) begin
            if (halted) begin
                cw[B_HLT] = 1'b1;
            end else begin
                case (step)
                    T0: begin
                        cw[B_CO] = 1'b1;
                        cw[B_MI] = 1'b1;
                    end
                    T1: begin
                        cw[B_RO] = 1'b1;
                        cw[B_II] = 1'b1;
                        cw[B_CE] = 1'b1;
                    end
                    T2: begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                cw[B_IO] = 1'b1;
                                cw[B_MI] = 1'b1;
                            end
                            OP_LDI: begin
                                cw[B_IO] = 1'b1;
                                cw[B_AI] = 1'b1;
                            end
                            OP_JMP: begin
                                cw[B_IO] = 1'b1;
                                cw[B_J]  = 1'b1;
                            end
                            OP_JC: begin
                                cw[B_IO] = 1'b1;
                                cw[B_J]  = bus.cf;
                            end
                            OP_JZ: begin
                                cw[B_IO] = 1'b1;
                                cw[B_J]  = bus.zf;
                            end
                            OP_OUT: begin
                                cw[B_AO] = 1'b1;
                                cw[B_OI] = 1'b1;
                            end
                            OP_HLT: cw[B_HLT] = 1'b1;
                            default: cw = '0;
                        endcase
                    end
                    T3: begin
                        case (opcode)
                            OP_LDA: begin
                                cw[B_RO] = 1'b1;
                                cw[B_AI] = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                cw[B_RO] = 1'b1;
                                cw[B_BI] = 1'b1;
                            end
                            OP_STA: begin
                                cw[B_AO] = 1'b1;
                                cw[B_RI] = 1'b1;
                            end
                            default: cw = '0;
                        endcase
                    end
                    T4: begin
                        if (opcode == OP_ADD || opcode == OP_SUB) begin
                            cw[B_EO] = 1'b1;
                            cw[B_AI] = 1'b1;
                            cw[B_FI] = 1'b1;
                            cw[B_SU] = (opcode == OP_SUB);
                        end
                    end
                    default: cw = '0;
                endcase
            end
        end
    end

    assign bus.stepval = step;
    assign bus.halted  = halted;
    assign bus.hlt     = cw[B_HLT];
    assign bus.mi      = cw[B_MI];
    assign bus.ri      = cw[B_RI];
    assign bus.ro      = cw[B_RO];
    assign bus.io      = cw[B_IO];
    assign bus.ii      = cw[B_II];
    assign bus.ai      = cw[B_AI];
    assign bus.ao      = cw[B_AO];
    assign bus.eo      = cw[B_EO];
    assign bus.su      = cw[B_SU];
    assign bus.bi      = cw[B_BI];
    assign bus.oi      = cw[B_OI];
    assign bus.ce      = cw[B_CE];
    assign bus.co      = cw[B_CO];
    assign bus.j       = cw[B_J];
    assign bus.fi      = cw[B_FI];
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a table-driven microprogram model predicts
// {halted, step, control word} for every cycle; a negedge monitor pops and
// compares them.
module tb_control_unit;
    localparam int N = 8;
    localparam int S = 3;
    localparam int W = 20;

    localparam logic [15:0] M_HLT = 16'h8000;
    localparam logic [15:0] M_MI  = 16'h4000;
    localparam logic [15:0] M_RI  = 16'h2000;
    localparam logic [15:0] M_RO  = 16'h1000;
    localparam logic [15:0] M_IO  = 16'h0800;
    localparam logic [15:0] M_II  = 16'h0400;
    localparam logic [15:0] M_AI  = 16'h0200;
    localparam logic [15:0] M_AO  = 16'h0100;
    localparam logic [15:0] M_EO  = 16'h0080;
    localparam logic [15:0] M_SU  = 16'h0040;
    localparam logic [15:0] M_BI  = 16'h0020;
    localparam logic [15:0] M_OI  = 16'h0010;
    localparam logic [15:0] M_CE  = 16'h0008;
    localparam logic [15:0] M_CO  = 16'h0004;
    localparam logic [15:0] M_J   = 16'h0002;
    localparam logic [15:0] M_FI  = 16'h0001;

    // clock/reset
    logic clk = 1'b0;
    logic clr_;
    logic prog;
    always #5 clk = ~clk;

    control_unit_if #(.N(N), .S(S)) bus ();

    control_unit #(.N(N), .S(S)) dut (
        .clk  (clk),
        .clr_ (clr_),
        .prog (prog),
        .bus  (bus.master)
    );

    // reference model: microprogram table plus instruction lengths
    logic [15:0] ucode [16][5];
    int          ulen  [16];
    int          m_step;
    bit          m_halted;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] dut_word();
        return {bus.hlt, bus.mi, bus.ri, bus.ro, bus.io, bus.ii, bus.ai, bus.ao,
                bus.eo, bus.su, bus.bi, bus.oi, bus.ce, bus.co, bus.j, bus.fi};
    endfunction

    function automatic logic [15:0] model_word(bit c, bit p, logic [3:0] op, bit cfv, bit zfv);
        logic [15:0] w;
        if (!c || !p) return 16'h0000;
        if (m_halted) return M_HLT;
        if (m_step == 0) return M_CO | M_MI;
        if (m_step == 1) return M_RO | M_II | M_CE;
        w = ucode[op][m_step];
        if (m_step == 2 && op == 4'h7 && cfv) w = w | M_J;
        if (m_step == 2 && op == 4'h8 && zfv) w = w | M_J;
        return w;
    endfunction

    // driver: apply one cycle of inputs, push prediction, advance model
    task automatic cycle(input bit c, input bit p, input logic [7:0] ir, input bit cfv, input bit zfv);
        logic [3:0] op;
        op = ir[7:4];
        clr_      = c;
        prog      = p;
        bus.irval = ir;
        bus.cf    = cfv;
        bus.zf    = zfv;
        if (!c) begin
            m_step   = 0;
            m_halted = 1'b0;
        end
        exp_q.push_back({m_halted, 3'(m_step), model_word(c, p, op, cfv, zfv)});
        @(posedge clk);
        #1;
        if (c) begin
            if (!p) begin
                m_step = 0;
            end else if (!m_halted) begin
                if (m_step == 2 && op == 4'hF) m_halted = 1'b1;
                else if (m_step + 1 >= ulen[op]) m_step = 0;
                else m_step = m_step + 1;
            end
        end
    endtask

    task automatic run(input logic [7:0] ir, input bit cfv, input bit zfv, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, ir, cfv, zfv);
    endtask

    // monitor: compare each predicted cycle and the single-bus-driver rule
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.halted, bus.stepval, dut_word()};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL word t=%0t actual halted/step/word=%0b/%0d/%04h required %0b/%0d/%04h",
                         $time, act_v[19], act_v[18:16], act_v[15:0], exp_v[19], exp_v[18:16], exp_v[15:0]);
            end
            checks++;
            if ($countones({bus.co, bus.ro, bus.io, bus.ao, bus.eo}) > 1) begin
                errors++;
                $display("FAIL bus_drivers t=%0t actual co/ro/io/ao/eo=%b required at most one",
                         $time, {bus.co, bus.ro, bus.io, bus.ao, bus.eo});
            end
        end
    end

    initial begin
        logic [7:0] ir;
        bit         c;
        bit         p;

        for (int o = 0; o < 16; o++) begin
            ulen[o] = 3;
            for (int s = 0; s < 5; s++) ucode[o][s] = 16'h0000;
        end
        ucode[1][2] = M_IO | M_MI; ucode[1][3] = M_RO | M_AI; ulen[1] = 4;
        ucode[2][2] = M_IO | M_MI; ucode[2][3] = M_RO | M_BI; ucode[2][4] = M_EO | M_AI | M_FI; ulen[2] = 5;
        ucode[3][2] = M_IO | M_MI; ucode[3][3] = M_RO | M_BI; ucode[3][4] = M_EO | M_AI | M_SU | M_FI; ulen[3] = 5;
        ucode[4][2] = M_IO | M_MI; ucode[4][3] = M_AO | M_RI; ulen[4] = 4;
        ucode[5][2] = M_IO | M_AI;
        ucode[6][2] = M_IO | M_J;
        ucode[7][2] = M_IO;
        ucode[8][2] = M_IO;
        ucode[14][2] = M_AO | M_OI;
        ucode[15][2] = M_HLT;
        m_step   = 0;
        m_halted = 1'b0;

        clr_      = 1'b0;
        prog      = 1'b0;
        bus.irval = '0;
        bus.cf    = 1'b0;
        bus.zf    = 1'b0;
        @(posedge clk);
        #1;

        // reset held across three edges with prog high
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h2F, 1'b0, 1'b0);
        // ADD and SUB full instructions
        run(8'h2F, 1'b0, 1'b0, 5);
        run(8'h3F, 1'b0, 1'b0, 5);
        // conditional jumps both ways
        run(8'h7A, 1'b0, 1'b0, 3);
        run(8'h7A, 1'b1, 1'b0, 3);
        run(8'h8A, 1'b0, 1'b0, 3);
        run(8'h8A, 1'b0, 1'b1, 3);
        // halt then hold for ten edges, then clear
        run(8'hF0, 1'b0, 1'b0, 13);
        cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        // LDA interrupted at step 3 by program mode
        run(8'h1E, 1'b0, 1'b0, 3);
        cycle(1'b1, 1'b0, 8'h1E, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h1E, 1'b0, 1'b0);
        run(8'h1E, 1'b0, 1'b0, 4);
        // unused opcodes behave as NOP
        for (int o = 9; o <= 13; o++) run({4'(o), 4'h5}, 1'b1, 1'b1, 3);
        // every opcode once, HLT last then cleared
        for (int o = 0; o < 15; o++) run({4'(o), 4'hA}, 1'b1, 1'b0, ulen[o]);
        run(8'hF3, 1'b0, 1'b0, 4);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // randomized: IR changes only at fetch, occasional prog drop and clear
        ir = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if (m_step == 0) ir = 8'($urandom_range(0, 255));
            c = ($urandom_range(0, 29) != 0);
            p = ($urandom_range(0, 14) != 0);
            cycle(c, p, ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
